hub75_bcm_scan: RTL and testbench
=================================

Name: hub75_bcm_scan

Overview:
- Scan engine for a 64x64 HUB75 panel (1/32 scan) driven from the 30 MHz PLL clock.
- Reads pixels from a framebuffer read port and shifts one bit-plane per row pair (row r and r+32).
- Modulates brightness with binary-code modulation (BCM).
- Drives RGB0/RGB1/ADDR/BLANK/LATCH/SCLK straight into the top-level pin mapping (SCLK via the ddr output cell).

Parameters:
- COLS, 64, pixels per row shifted per plane.
- HALF_ROWS, 32, row pairs per frame; ADDR width = log2(HALF_ROWS) = 5.
- BPC, 4, bits per colour channel (bit-planes).
- BASE_TICKS, 64, on-time in clk cycles of plane 0; plane b lit BASE_TICKS<<b.
- AW, 12, framebuffer address width = log2(2*HALF_ROWS*COLS).

Ports:
- clk  in  1  pixel/scan clock (PLL 30 MHz).
- reset  in  1  synchronous, active-high reset.
- fb_addr  out  AW  framebuffer read address {half, row[4:0], col[5:0]}; half=1 selects rows 32..63.
- fb_rd  out  1  read strobe; data valid on fb_rdata exactly 1 cycle later.
- fb_rdata  in  3*BPC  pixel {R[BPC-1:0], G[BPC-1:0], B[BPC-1:0]}.
- RGB0  out  3  upper-half bit {B,G,R} at [2:0] = {B,G,R}; bit0=R.
- RGB1  out  3  lower-half bit, same packing.
- ADDR  out  5  row pair currently displayed.
- BLANK  out  1  1 = panel outputs off.
- LATCH  out  1  1-cycle strobe transferring shift register to outputs.
- SCLK  out  1  panel shift clock; panel samples on rising edge.
- frame_start  out  1  1-cycle pulse when row 0 plane 0 shifting begins.

Behaviour:
- Reset (sync, active-high): BLANK=1; RGB0, RGB1, ADDR, LATCH, SCLK, fb_rd, fb_addr and frame_start = 0.
- Reset clears FSM to SHIFT at row 0, plane 0, column 0. Display timer is cleared and treated as expired.
- Reset mid-frame aborts immediately; the next cycle obeys reset values.
- Column pipeline: 4 clocks per column, phase counter p=0..3.
  - p0: fb_rd=1, fb_addr={0,r,c}.
  - p1: fb_rd=1, fb_addr={1,r,c}; capture upper pixel.
  - p2: capture lower pixel. RGB0/RGB1 = bit b of each channel. SCLK=0.
  - p3: SCLK=1, data held stable.
  - One plane shift = 4*COLS = 256 clocks. SCLK is 0 in all other states.
- Main FSM states: SHIFT, WAIT, BLANK_PRE, LATCH_S, UNBLANK.
- SHIFT: runs the column pipeline.
  - After p3 of col COLS-1, go to WAIT.
- WAIT: hold until display timer == 0, then go to BLANK_PRE.
  - If the timer has already expired at entry, WAIT lasts exactly 1 cycle.
- BLANK_PRE: BLANK=1 for 2 cycles. ADDR updates to r_shifted on the first of them.
- LATCH_S: LATCH=1 for exactly 1 cycle, BLANK stays 1.
- UNBLANK: BLANK=0 and timer loaded with BASE_TICKS<<b_shifted.
  - Plane counter advances: b+1; on b==BPC-1, b=0 and r+1; on r==HALF_ROWS-1, r=0.
  - Then enter SHIFT for the next plane. This state lasts 1 cycle.
- Display timer: decrements each cycle while nonzero; independent of FSM, so display overlaps the next shift.
  - Timer width = log2(BASE_TICKS<<(BPC-1))+1.
- BLANK: 0 only between UNBLANK and the next BLANK_PRE.
  - The first plane after reset stays blanked until its first latch.
- frame_start: asserted on the first SHIFT cycle of r=0, b=0, including the one right after reset.
- fb_addr holds its last value when fb_rd=0.
- No backpressure: framebuffer must honour the fixed 1-cycle read latency.

Decomposition:
- Shared package hub75_pkg: COLS, HALF_ROWS, BPC, AW constants.
- Shared package also holds the FSM state enum and a pixel-bit-extract function (pixel, b) -> {B,G,R}.
- One sub-module is natural: bcm_timer (loadable down-counter with zero flag).

Test Plan:
- Reset held 3 cycles mid-SHIFT -> next cycle BLANK=1, SCLK=LATCH=ADDR=RGB0=RGB1=0; shifting restarts at fb_addr=0x000 with frame_start=1.
- Framebuffer model returning fb_rdata=0xF00 upper, 0x00F lower -> exactly 64 SCLK rising edges per plane, each with RGB0=3'b001, RGB1=3'b100, period 4 clocks.
- Fb_addr sequence for col 5, row 3 -> 0x0C5 then 0x8C5 on consecutive cycles with fb_rd=1.
- Latch sequence -> BLANK=1 for 2 cycles, LATCH=1 for 1 cycle with ADDR=r, then BLANK=0; LATCH never coincides with SCLK=1.
- Plane 3 of row 7 (BASE_TICKS=64) -> BLANK low for 512 clocks plus WAIT overhead; next latch occurs 0 cycles before timer hits 0. Plane 0 latch interval is bounded by 256-clock shift, not the timer.
- Full frame run -> 128 latches, ADDR walks 0..31 each held for 4 planes, frame_start pulses once per frame, ADDR wraps 31->0.

Source files
------------

// File: rtl/hub75_bcm_scan_pkg.sv
// Shared constants, scan FSM states and bit-plane extraction for the HUB75 BCM scan engine.
package hub75_pkg;

   localparam int COLS       = 64;
   localparam int HALF_ROWS  = 32;
   localparam int BPC        = 4;
   localparam int BASE_TICKS = 64;
   localparam int AW         = 12;
   localparam int COL_W      = $clog2(COLS);
   localparam int ROW_W      = $clog2(HALF_ROWS);
   localparam int PLANE_W    = $clog2(BPC);
   localparam int TIMER_W    = $clog2(BASE_TICKS << (BPC - 1)) + 1;
   localparam int PIX_W      = 3 * BPC;

   typedef enum logic [2:0] {
      SHIFT,
      WAIT,
      BLANK_PRE,
      LATCH_S,
      UNBLANK
   } scan_state_t;

   // Pixel is {R,G,B}; the panel wants {B,G,R} with R in bit 0.
   function automatic logic [2:0] pixel_bits(input logic [PIX_W-1:0] pixel,
                                             input logic [PLANE_W-1:0] b);
      logic [BPC-1:0] r_ch;
      logic [BPC-1:0] g_ch;
      logic [BPC-1:0] b_ch;
      r_ch = pixel[2*BPC +: BPC];
      g_ch = pixel[BPC +: BPC];
      b_ch = pixel[0 +: BPC];
      return {b_ch[b], g_ch[b], r_ch[b]};
   endfunction

endpackage

// File: rtl/hub75_bcm_scan_if.sv
// Framebuffer read port: address/strobe out of the scan engine, pixel data back one cycle later.
interface hub75_bcm_scan_if;
   import hub75_pkg::*;

   logic [AW-1:0]    fb_addr;
   logic             fb_rd;
   logic [PIX_W-1:0] fb_rdata;

   modport master (output fb_addr, output fb_rd, input fb_rdata);
   modport slave  (input fb_addr, input fb_rd, output fb_rdata);

endinterface

// File: rtl/hub75_bcm_scan_bcm_timer.sv
// Loadable down-counter that stops at zero; reset leaves it expired.
module bcm_timer
   import hub75_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_value,
   output logic               zero
);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_value;
      else if (count != '0)
         count <= count - TIMER_W'(1);
   end

   assign zero = (count == '0);

endmodule

// File: rtl/hub75_bcm_scan.sv
// HUB75 64x64 1/32-scan engine: shifts one bit-plane per row pair and times it with BCM.
module hub75_bcm_scan
   import hub75_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   hub75_bcm_scan_if.master   fb,
   output logic [2:0]         RGB0,
   output logic [2:0]         RGB1,
   output logic [ROW_W-1:0]   ADDR,
   output logic               BLANK,
   output logic               LATCH,
   output logic               SCLK,
   output logic               frame_start
);

   scan_state_t        state, state_next;
   logic               run;
   logic [1:0]         phase, phase_next;
   logic [COL_W-1:0]   col, col_next;
   logic [ROW_W-1:0]   row, row_next;
   logic [PLANE_W-1:0] plane, plane_next;
   logic [PIX_W-1:0]   upper_pix;
   logic [2:0]         rgb0_q, rgb1_q;
   logic [AW-1:0]      addr_hold, fb_addr_c;
   logic               fb_rd_c, blank_q, shifting;
   logic               timer_load, timer_zero;
   logic [TIMER_W-1:0] timer_value;

   // run stays low for the first cycle out of reset so every pin shows its reset value then.
   always_ff @(posedge clk) begin
      if (reset) begin
         run   <= 1'b0;
         state <= SHIFT;
         phase <= '0;
         col   <= '0;
         row   <= '0;
         plane <= '0;
      end else begin
         run   <= 1'b1;
         state <= state_next;
         phase <= phase_next;
         col   <= col_next;
         row   <= row_next;
         plane <= plane_next;
      end
   end

   always_comb begin
      state_next = state;
      phase_next = phase;
      col_next   = col;
      row_next   = row;
      plane_next = plane;
      timer_load = 1'b0;
      if (run) begin
         unique case (state)
            SHIFT: begin
               phase_next = phase + 2'd1;
               if (phase == 2'd3) begin
                  if (col == COL_W'(COLS - 1)) begin
                     col_next   = '0;
                     state_next = WAIT;
                  end else begin
                     col_next = col + COL_W'(1);
                  end
               end
            end
            WAIT: begin
               if (timer_zero)
                  state_next = BLANK_PRE;
            end
            BLANK_PRE: begin
               phase_next = phase + 2'd1;
               if (phase == 2'd1) begin
                  phase_next = '0;
                  state_next = LATCH_S;
               end
            end
            LATCH_S: state_next = UNBLANK;
            UNBLANK: begin
               timer_load = 1'b1;
               state_next = SHIFT;
               if (plane == PLANE_W'(BPC - 1)) begin
                  plane_next = '0;
                  row_next   = (row == ROW_W'(HALF_ROWS - 1)) ? '0 : row + ROW_W'(1);
               end else begin
                  plane_next = plane + PLANE_W'(1);
               end
            end
            default: state_next = SHIFT;
         endcase
      end
   end

   assign timer_value = TIMER_W'(BASE_TICKS) << plane;

   bcm_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_value),
      .zero       (timer_zero)
   );

   // Lower pixel arrives during p2 and goes straight to RGB1; the registered copy holds it through p3.
   always_comb begin
      shifting    = run && (state == SHIFT);
      fb_rd_c     = shifting && !phase[1];
      fb_addr_c   = addr_hold;
      if (shifting && phase == 2'd0)
         fb_addr_c = {1'b0, row, col};
      else if (shifting && phase == 2'd1)
         fb_addr_c = {1'b1, row, col};
      RGB0 = rgb0_q;
      RGB1 = rgb1_q;
      if (shifting && phase == 2'd2) begin
         RGB0 = pixel_bits(upper_pix, plane);
         RGB1 = pixel_bits(fb.fb_rdata, plane);
      end
      BLANK = blank_q;
      if (!run || state == BLANK_PRE || state == LATCH_S)
         BLANK = 1'b1;
      else if (state == UNBLANK)
         BLANK = 1'b0;
      SCLK        = shifting && (phase == 2'd3);
      LATCH       = run && (state == LATCH_S);
      frame_start = shifting && (phase == 2'd0) && (col == '0) && (row == '0) && (plane == '0);
   end

   assign fb.fb_addr = fb_addr_c;
   assign fb.fb_rd   = fb_rd_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         upper_pix <= '0;
         rgb0_q    <= '0;
         rgb1_q    <= '0;
         addr_hold <= '0;
         blank_q   <= 1'b1;
         ADDR      <= '0;
      end else begin
         addr_hold <= fb_addr_c;
         blank_q   <= BLANK;
         rgb0_q    <= RGB0;
         rgb1_q    <= RGB1;
         if (shifting && phase == 2'd1)
            upper_pix <= fb.fb_rdata;
         if (run && state == WAIT && timer_zero)
            ADDR <= row;
      end
   end

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Scoreboard bench for hub75_bcm_scan: framebuffer model pushes expectations, a monitor pops and checks them.
module tb_hub75_bcm_scan;
   import hub75_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] RGB0, RGB1;
   logic [4:0] ADDR;
   logic       BLANK, LATCH, SCLK, frame_start;

   always #16 clk = ~clk;

   hub75_bcm_scan_if fb ();

   hub75_bcm_scan dut (
      .clk         (clk),
      .reset       (reset),
      .fb          (fb),
      .RGB0        (RGB0),
      .RGB1        (RGB1),
      .ADDR        (ADDR),
      .BLANK       (BLANK),
      .LATCH       (LATCH),
      .SCLK        (SCLK),
      .frame_start (frame_start)
   );

   int tests = 0;
   int fails = 0;
   int mode  = 0;

   typedef struct packed { logic [2:0] rgb0; logic [2:0] rgb1; } rgb_exp_t;
   typedef struct packed { logic [4:0] row; logic [1:0] plane; } latch_exp_t;
   rgb_exp_t   rgbQ[$];
   latch_exp_t latchQ[$];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [11:0] pixelAt(input logic [11:0] a);
      if (mode == 0)
         return a[11] ? 12'h00F : 12'hF00;
      return a ^ 12'hA5C;
   endfunction

   function automatic logic [2:0] planeBits(input logic [11:0] pix, input int b);
      return {pix[b], pix[4+b], pix[8+b]};
   endfunction

   function automatic int expLow(input int b);
      int t;
      t = 64 << b;
      return ((t > 256) ? t : 256) + 2;
   endfunction

   // Framebuffer model: serves reads with 1-cycle latency and queues the expected panel data.
   logic        rdPend = 1'b0;
   logic [11:0] rdAddr = '0;
   logic [11:0] upperPix;
   logic        prevUpper;
   int halfM, colM, rowM, planeM;

   always @(posedge clk)
      if (rdPend) fb.fb_rdata <= pixelAt(rdAddr);

   always @(negedge clk) begin
      logic        wasUpper;
      logic [11:0] expAddr;
      rgb_exp_t    e;
      latch_exp_t  l;
      if (reset) begin
         rdPend <= 1'b0;
         halfM = 0; colM = 0; rowM = 0; planeM = 0;
         prevUpper = 1'b0;
         rgbQ.delete();
         latchQ.delete();
      end else begin
         rdPend <= fb.fb_rd;
         rdAddr <= fb.fb_addr;
         wasUpper = prevUpper;
         prevUpper = 1'b0;
         if (fb.fb_rd) begin
            expAddr = {halfM[0], rowM[4:0], colM[5:0]};
            checkOutput("fb_addr", fb.fb_addr, expAddr);
            if (halfM == 0) begin
               upperPix  = pixelAt(expAddr);
               halfM     = 1;
               prevUpper = 1'b1;
            end else begin
               checkOutput("lower read follows upper", wasUpper, 1);
               e.rgb0 = planeBits(upperPix, planeM);
               e.rgb1 = planeBits(pixelAt(expAddr), planeM);
               rgbQ.push_back(e);
               halfM = 0;
               colM++;
               if (colM == 64) begin
                  colM = 0;
                  l.row   = rowM[4:0];
                  l.plane = planeM[1:0];
                  latchQ.push_back(l);
                  planeM++;
                  if (planeM == 4) begin
                     planeM = 0;
                     rowM = (rowM + 1) % 32;
                  end
               end
            end
         end
      end
   end

   // Monitor: pops expectations on SCLK rising and LATCH, and checks blanking/frame timing.
   int sclkCount, sinceSclk, sinceLatch, lowLen, frameCount, latchesInFrame, prevPlane;
   logic prevSclk, prevBlank, blankHist1, blankHist2, expectUnblank, havePrevLatch;

   always @(negedge clk) begin
      rgb_exp_t   e;
      latch_exp_t l;
      if (reset) begin
         sclkCount = 0; sinceSclk = 0; sinceLatch = 0; lowLen = 0;
         frameCount = 0; latchesInFrame = 0; prevPlane = 0;
         prevSclk = 1'b0; prevBlank = 1'b1; blankHist1 = 1'b1; blankHist2 = 1'b1;
         expectUnblank = 1'b0; havePrevLatch = 1'b0;
      end else begin
         sinceSclk++;
         sinceLatch++;
         if (SCLK && !prevSclk) begin
            if (sclkCount > 0) checkOutput("SCLK period", sinceSclk, 4);
            sinceSclk = 0;
            sclkCount++;
            if (rgbQ.size() == 0) begin
               tests++; fails++;
               $display("[TB] FAIL rgb scoreboard: SCLK edge with no expected data at %0t", $time);
            end else begin
               e = rgbQ.pop_front();
               checkOutput("RGB0", RGB0, e.rgb0);
               checkOutput("RGB1", RGB1, e.rgb1);
            end
         end
         if (expectUnblank) begin
            checkOutput("BLANK after latch", BLANK, 0);
            checkOutput("LATCH width", LATCH, 0);
            expectUnblank = 1'b0;
            lowLen = 0;
         end
         if (LATCH) begin
            checkOutput("SCLK during latch", SCLK, 0);
            checkOutput("BLANK during latch", BLANK, 1);
            checkOutput("BLANK before latch", {blankHist2, blankHist1}, 2'b11);
            checkOutput("SCLK edges per plane", sclkCount, 64);
            sclkCount = 0;
            if (latchQ.size() == 0) begin
               tests++; fails++;
               $display("[TB] FAIL latch scoreboard: LATCH with no expected row at %0t", $time);
            end else begin
               l = latchQ.pop_front();
               checkOutput("ADDR at latch", ADDR, l.row);
               if (havePrevLatch) checkOutput("latch interval", sinceLatch, expLow(prevPlane) + 3);
               prevPlane = l.plane;
            end
            havePrevLatch = 1'b1;
            sinceLatch = 0;
            expectUnblank = 1'b1;
            latchesInFrame++;
         end
         if (!BLANK) lowLen++;
         if (BLANK && !prevBlank && havePrevLatch) begin
            checkOutput("BLANK low time", lowLen, expLow(prevPlane));
            lowLen = 0;
         end
         if (frame_start) begin
            checkOutput("frame_start fb_addr", fb.fb_addr, 0);
            checkOutput("frame_start fb_rd", fb.fb_rd, 1);
            if (frameCount > 0) checkOutput("latches per frame", latchesInFrame, 128);
            latchesInFrame = 0;
            frameCount++;
         end
         blankHist2 = blankHist1;
         blankHist1 = BLANK;
         prevBlank  = BLANK;
         prevSclk   = SCLK;
      end
   end

   // Holds reset for n cycles checking reset values each cycle, then checks the restart cycle.
   task automatic applyStimulus(input int n, input int newMode);
      reset = 1'b1;
      mode  = newMode;
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("reset BLANK", BLANK, 1);
         checkOutput("reset SCLK", SCLK, 0);
         checkOutput("reset LATCH", LATCH, 0);
         checkOutput("reset ADDR", ADDR, 0);
         checkOutput("reset RGB0", RGB0, 0);
         checkOutput("reset RGB1", RGB1, 0);
         checkOutput("reset fb_rd", fb.fb_rd, 0);
         checkOutput("reset fb_addr", fb.fb_addr, 0);
         checkOutput("reset frame_start", frame_start, 0);
      end
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("restart fb_rd", fb.fb_rd, 1);
      checkOutput("restart fb_addr", fb.fb_addr, 12'h000);
      checkOutput("restart frame_start", frame_start, 1);
      checkOutput("restart BLANK", BLANK, 1);
   endtask

   initial begin
      @(negedge clk);
      applyStimulus(3, 0);
      repeat (700) @(negedge clk);
      applyStimulus(3, 1);
      for (int i = 0; i < 45000 && frameCount < 2; i++) @(negedge clk);
      checkOutput("frames seen before timeout", frameCount, 2);
      repeat (20) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
